// File: rtl/ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ram_fifo_ctrl
//   256-word x 16-bit FIFO controller. The external single-port RAM (256x16,
//   synchronous read, one cycle of read latency) holds the stored words.
//   The registered output word rd_data is the head of the queue. Total
//   capacity is 256 words, counting the word held in rd_data.
//
//   Only one RAM access happens per cycle. A head fetch takes priority over a
//   producer write, so wr_ready drops during a fetch cycle.
//
// Optional feature (compile-time macro):
//   RAM_FIFO_BYPASS_EN - when defined, a word accepted while the FIFO is
//                        completely empty goes straight into rd_data. It is
//                        visible one cycle later and causes no RAM write.
//                        When undefined, every word is routed through the RAM.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   wr_valid  - producer offers wr_data
//   wr_ready  - controller accepts wr_data this cycle
//   wr_data   - word to enqueue
//   rd_valid  - rd_data holds the head word
//   rd_ready  - consumer takes the head word
//   rd_data   - registered head word
//   count     - words held (0..256)
//   full      - count == 256
//   empty     - count == 0
//   ram_we    - RAM write strobe
//   ram_addr  - RAM address (holds the last write address when idle)
//   ram_din   - RAM write data
//   ram_dout  - RAM read data, valid one cycle after the address is sampled
// ----------------------------------------------------------------------------
module ram_fifo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic [8:0]  count,
  output logic        full,
  output logic        empty,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout
);

  localparam logic [8:0] DEPTH = 9'd256;

  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic [7:0] last_waddr;
  logic       fetch_pend;

  logic [8:0] ram_cnt;
  logic       pop;
  logic       fetch;
  logic       accept;
  logic       bypass;
  logic       ram_write;

  // Words still waiting in RAM. A word with a fetch in flight, or a word
  // already sitting in rd_data, is counted in count but is not in RAM any more.
  // rd_valid and fetch_pend are never high together.
  assign ram_cnt = count - {8'd0, rd_valid} - {8'd0, fetch_pend};

  assign pop    = rd_valid && rd_ready;
  assign fetch  = rst_n && (ram_cnt != 9'd0) && !fetch_pend && (!rd_valid || pop);
  assign full   = (count == DEPTH);
  assign empty  = (count == 9'd0);

  // The fetch owns the RAM port this cycle, so the producer must wait.
  assign wr_ready = rst_n && !full && !fetch;
  assign accept   = wr_valid && wr_ready;

`ifdef RAM_FIFO_BYPASS_EN
  // count == 0 means that nothing is in RAM, nothing is in flight, and
  // rd_data is free.
  assign bypass = accept && (count == 9'd0) && !fetch_pend;
`else
  assign bypass = 1'b0;
`endif

  assign ram_write = accept && !bypass;
  assign ram_din   = wr_data;

  // NOTE: every output of a combinational block is given a default value
  // first, so no path leaves it unassigned. That avoids an inferred latch.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = last_waddr;
    if (fetch) begin
      ram_addr = rd_ptr;
    end else if (ram_write) begin
      ram_we   = 1'b1;
      ram_addr = wr_ptr;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // As a result, every right-hand side sees the value from before the clock
  // edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 8'd0;
      rd_ptr     <= 8'd0;
      last_waddr <= 8'd0;
      count      <= 9'd0;
      fetch_pend <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 16'h0000;
    end else begin
      if (ram_write) begin
        wr_ptr     <= wr_ptr + 8'd1;
        last_waddr <= wr_ptr;
      end

      if (fetch) begin
        rd_ptr <= rd_ptr + 8'd1;
      end
      fetch_pend <= fetch;

      // A landing fetch and a bypass load both refill the head register.
      // A landing fetch implies that rd_valid was low, so no pop can coincide
      // with it.
      if (fetch_pend) begin
        rd_data  <= ram_dout;
        rd_valid <= 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end

      unique case ({accept, pop})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//   Self-checking bench for ram_fifo_ctrl. It includes a behavioural model of
//   the 256x16 synchronous single-port RAM.
//
//   The bench drives inputs just after the falling edge and samples outputs
//   1 ns later.
//
//   When a word is accepted, it is pushed to a queue. When the consumer pops a
//   word, the front of the queue is compared with rd_data.
//
//   The bench also keeps an independent count model, which is checked every
//   cycle.
// ----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [8:0]  count;
  logic        full;
  logic        empty;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [256];
  logic [15:0] sb [$];
  int          cnt_m;
  int          checks;
  int          failures;
  int          stalls;

  ram_fifo_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: write, or read with one cycle of latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive the inputs, sample the outputs, update the scoreboard
  // and the count model.
  task automatic tick(input logic wv, input logic [15:0] wd, input logic rr,
                      output logic acc, output logic popped);
    logic [15:0] exp_word;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    check("count", {23'd0, count}, cnt_m[31:0]);
    check("full", {31'd0, full}, {31'd0, (cnt_m == 256)});
    check("empty", {31'd0, empty}, {31'd0, (cnt_m == 0)});
    acc    = wv && wr_ready;
    popped = rd_valid && rr;
    if (wv && !wr_ready && !full) begin
      stalls++;
      check("stall_ram_we", {31'd0, ram_we}, 32'd0);
    end
    if (acc) sb.push_back(wd);
    if (popped) begin
      if (sb.size() == 0) begin
        check("pop_with_empty_scoreboard", {31'd0, rd_valid}, 32'd0);
      end else begin
        exp_word = sb.pop_front();
        check("rd_data", {16'd0, rd_data}, {16'd0, exp_word});
      end
    end
    cnt_m = cnt_m + (acc ? 1 : 0) - (popped ? 1 : 0);
  endtask

  task automatic push_word(input logic [15:0] wd);
    logic acc, pp;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) tick(1'b1, wd, 1'b0, acc, pp);
    if (!acc) check("push_timeout_wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic pop_word();
    logic acc, pp;
    pp = 1'b0;
    for (int i = 0; i < 16 && !pp; i++) tick(1'b0, 16'h0000, 1'b1, acc, pp);
    if (!pp) check("pop_timeout_rd_valid", {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #1;
    check("rst_count", {23'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    sb.delete();
    cnt_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("post_rst_count", {23'd0, count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, pp, prev_stall;
    logic [15:0] d;
    int lat;
    int n;
    checks   = 0;
    failures = 0;
    stalls   = 0;
    cnt_m    = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0000;
    rd_ready = 1'b0;

    // Reset behaviour.
    do_reset();

    // A single word pushed into an empty FIFO.
    tick(1'b1, 16'h5A5A, 1'b0, acc, pp);
    check("5a5a_accept", {31'd0, acc}, 32'd1);
`ifdef RAM_FIFO_BYPASS_EN
    check("5a5a_ram_we", {31'd0, ram_we}, 32'd0);
    lat = 1;
`else
    check("5a5a_ram_we", {31'd0, ram_we}, 32'd1);
    check("5a5a_ram_addr", {24'd0, ram_addr}, 32'd0);
    lat = 3;
`endif
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 16'h0000, 1'b0, acc, pp);
      check($sformatf("5a5a_rd_valid_c%0d", k), {31'd0, rd_valid}, {31'd0, (k >= lat)});
      check($sformatf("5a5a_ram_we_c%0d", k), {31'd0, ram_we}, 32'd0);
    end
    pop_word();

    // Three words come out in order.
    push_word(16'hAAAA);
    push_word(16'hBBBB);
    push_word(16'hCCCC);
    repeat (3) pop_word();
    tick(1'b0, 16'h0000, 1'b0, acc, pp);
    check("abc_empty", {31'd0, empty}, 32'd1);
    check("abc_scoreboard_drained", sb.size(), 32'd0);

    // Reset in the middle of operation.
    for (int i = 0; i < 10; i++) push_word(16'h0100 + 16'(i));
    do_reset();
    push_word(16'h1234);
    pop_word();
    tick(1'b0, 16'h0000, 1'b0, acc, pp);
    check("rst_mid_empty", {31'd0, empty}, 32'd1);

    // Fill to capacity, drop the 257th word, then drain.
    do_reset();
    for (int i = 0; i < 256; i++) push_word(16'(i));
    tick(1'b1, 16'hDEAD, 1'b0, acc, pp);
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("full_ram_we", {31'd0, ram_we}, 32'd0);
    check("full_count", {23'd0, count}, 32'd256);
    tick(1'b0, 16'h0000, 1'b0, acc, pp);
    for (int i = 0; i < 256; i++) pop_word();
    tick(1'b0, 16'h0000, 1'b0, acc, pp);
    check("drain_empty", {31'd0, empty}, 32'd1);
`ifndef RAM_FIFO_BYPASS_EN
    // After 256 writes, the write pointer has wrapped back to 0.
    push_word(16'h7777);
    check("wrap_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("wrap_ram_we", {31'd0, ram_we}, 32'd1);
    pop_word();
`endif

    // Continuous producer and consumer. Fetch cycles stall the producer
    // for exactly one cycle.
    d = 16'h3000;
    prev_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, d, 1'b1, acc, pp);
      if (prev_stall) check("accept_after_stall", {31'd0, acc}, 32'd1);
      prev_stall = !acc;
      if (acc) d = d + 16'd1;
    end
    check("stall_seen", {31'd0, (stalls != 0)}, 32'd1);
    n = sb.size();
    for (int i = 0; i < n; i++) pop_word();
    tick(1'b0, 16'h0000, 1'b0, acc, pp);
    check("stream_empty", {31'd0, empty}, 32'd1);
    check("stream_scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port wr_valid, input, 1 bit: producer offers wr_data.
REQ-004 SHALL have port wr_ready, output, 1 bit: controller accepts the word this cycle.
REQ-005 SHALL have port wr_data, input, 16 bits: word to enqueue.
REQ-006 SHALL have port rd_valid, output, 1 bit: rd_data holds the head word.
REQ-007 SHALL have port rd_ready, input, 1 bit: consumer takes the head word.
REQ-008 SHALL have port rd_data, output, 16 bits: registered head word.
REQ-009 SHALL have port count, output, 9 bits: words held, range 0..256.
REQ-010 SHALL have ports full and empty, outputs, 1 bit each: count==256 and count==0 respectively.
REQ-011 SHALL have port ram_we, output, 1 bit: write strobe to the 256x16 single-port RAM.
REQ-012 SHALL have port ram_addr, output, 8 bits: RAM address.
REQ-013 SHALL have port ram_din, output, 16 bits: RAM write data.
REQ-014 SHALL have port ram_dout, input, 16 bits: RAM read data, valid one cycle after the address is sampled.

Function
REQ-015 SHALL implement a 256-word FIFO whose storage is the external RAM plus one output register (rd_data); total capacity 256.
REQ-016 SHALL make at most one RAM access per cycle; ram_we, ram_addr and ram_din are combinational from current state and inputs.
REQ-017 SHALL issue a fetch (ram_we=0, ram_addr=rd_ptr) when RAM holds >=1 word, no fetch is pending, and rd_valid==0 or a pop occurs this cycle.
REQ-018 SHALL load rd_data from ram_dout at the edge ending the cycle after a fetch, with rd_valid high from the following cycle; rd_ptr increments on fetch, wrapping 255->0.
REQ-019 SHALL give a fetch priority over a write: wr_ready = !full && !fetch_this_cycle.
REQ-020 SHALL, on wr_valid && wr_ready, drive ram_we=1, ram_addr=wr_ptr, ram_din=wr_data; wr_ptr increments, wrapping 255->0.
REQ-021 SHALL treat rd_valid && rd_ready as a pop: rd_valid clears next cycle unless refilled by a fetch landing that edge.
REQ-022 SHALL increment count on accept, decrement on pop, and leave it unchanged on a simultaneous accept and pop.
REQ-023 SHALL ignore wr_valid while full and ignore rd_ready while rd_valid==0; pointers and count unchanged.
REQ-024 SHALL hold ram_addr at the last write address and ram_we=0 when idle.

Reset
REQ-025 SHALL, while rst_n==0, immediately force wr_ptr=0, rd_ptr=0, count=0, fetch-pending=0, rd_valid=0, rd_data=16'h0000, ram_we=0, empty=1, full=0, wr_ready=0.
REQ-026 SHALL drop any in-flight fetch or write on reset mid-operation; RAM contents are not cleared and SHALL not be readable after reset.
REQ-027 SHALL assert wr_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with RAM_FIFO_BYPASS_EN defined, write an accepted word directly into rd_data with no RAM access (ram_we=0) when count==0 and no fetch is pending; rd_valid is high next cycle and wr_ptr/rd_ptr are unchanged.
REQ-029 SHALL, without RAM_FIFO_BYPASS_EN, route every accepted word through the RAM; a word pushed into an empty FIFO appears on rd_valid 3 cycles after acceptance.

Verification
REQ-030 SHALL cover: hold rst_n=0 -> count=0, empty=1, full=0, rd_valid=0, ram_we=0; release -> wr_ready=1.
REQ-031 SHALL cover: push AAAA, BBBB, CCCC, then pop with rd_ready=1 -> rd_data AAAA, BBBB, CCCC in order; empty=1 afterwards.
REQ-032 SHALL cover: push 0x0000..0x00FF with no pops -> full=1, wr_ready=0, 257th push (0xDEAD) dropped; drain -> 0x0000..0x00FF in order, pointers wrap to 0.
REQ-033 SHALL cover: wr_valid held during a fetch cycle -> ram_we=0, wr_ready=0 that cycle; word accepted next cycle, no loss or duplication.
REQ-034 SHALL cover: assert rst_n=0 after 10 pushes -> count=0 at once; then push 1234 and pop -> 1234 returned.
REQ-035 SHALL cover: push 5A5A into an empty FIFO -> with RAM_FIFO_BYPASS_EN, rd_valid the next cycle and ram_we stays 0; without it, ram_we=1 at ram_addr=8'h00 and rd_valid 3 cycles later.
